// File: rtl/pc_tgt_pkg.sv
// Shared types for the programmable branch-target table and its resolver.
package pc_tgt_pkg;

  localparam int TGT_D_DEFAULT = 12;

  typedef struct packed {
    logic                     rel;
    logic [TGT_D_DEFAULT-1:0] val;
  } tgt_entry_t;

  typedef enum logic {
    INIT,
    RUN
  } tgt_state_e;

  localparam logic [TGT_D_DEFAULT-1:0] TGT_CLEAR_VAL = '0;

endpackage

// File: rtl/pc_tgt_resolve.sv
// Combinational target resolver: absolute entries pass through, relative entries add to pc.
module pc_tgt_resolve #(
  parameter int D = 12
) (
  input  logic         rel,
  input  logic [D-1:0] val,
  input  logic [D-1:0] pc,
  output logic [D-1:0] target
);

  // D-bit add wraps silently, which gives two's-complement offsets for free
  assign target = rel ? (pc + val) : val;

endmodule

// File: rtl/pc_target_table.sv
// Programmable branch-target table with self-clearing init and 1-cycle lookup.
// Define PC_TGT_FWD_EN to forward a same-cycle write into a lookup of the same index.
module pc_target_table #(
  parameter int D = 12,
  parameter int N = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 clr,
  input  logic                 lookup_req,
  input  logic [$clog2(N)-1:0] lut_idx,
  input  logic [D-1:0]         pc_in,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [D-1:0]         wr_data,
  input  logic                 wr_rel,
  output logic                 ready,
  output logic                 tgt_valid,
  output logic [D-1:0]         target
);

  import pc_tgt_pkg::*;

  localparam int IW = $clog2(N);
  localparam logic [IW:0]   N_EXT    = (IW+1)'(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

  typedef struct packed {
    logic         rel;
    logic [D-1:0] val;
  } entry_t;

  entry_t        mem [N];
  tgt_state_e    state, next_state;
  logic [IW-1:0] cnt, next_cnt;
  logic          init_we;
  logic          in_run;
  logic          wr_ok;
  logic          lut_in_range;
  logic          take_lookup;
  entry_t        rd_entry;
  logic [D-1:0]  resolved;

  assign ready        = (state == RUN);
  assign in_run       = (state == RUN) && !clr;
  assign wr_ok        = in_run && wr_en && ({1'b0, wr_idx} < N_EXT);
  assign lut_in_range = ({1'b0, lut_idx} < N_EXT);
  assign take_lookup  = in_run && lookup_req;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    init_we    = 1'b0;
    case (state)
      INIT: begin
        init_we = 1'b1;
        if (clr) begin
          next_cnt = '0;
        end else if (cnt == LAST_IDX) begin
          next_state = RUN;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      RUN: begin
        if (clr) begin
          next_state = INIT;
          next_cnt   = '0;
        end
      end
      default: begin
        next_state = INIT;
        next_cnt   = '0;
      end
    endcase
  end

  // Table contents need no reset; the init sequencer clears them before ready rises
  always_ff @(posedge Clk) begin
    if (init_we) begin
      mem[cnt] <= '{rel: 1'b0, val: D'(TGT_CLEAR_VAL)};
    end else if (wr_ok) begin
      mem[wr_idx] <= '{rel: wr_rel, val: wr_data};
    end
  end

  always_comb begin
    rd_entry = '0;
    if (lut_in_range) begin
      rd_entry = mem[lut_idx];
    end
`ifdef PC_TGT_FWD_EN
    if (wr_ok && (wr_idx == lut_idx)) begin
      rd_entry = '{rel: wr_rel, val: wr_data};
    end
`endif
  end

  pc_tgt_resolve #(
    .D(D)
  ) u_resolve (
    .rel   (rd_entry.rel),
    .val   (rd_entry.val),
    .pc    (pc_in),
    .target(resolved)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tgt_valid <= 1'b0;
      target    <= '0;
    end else begin
      tgt_valid <= take_lookup;
      if (take_lookup) begin
        target <= resolved;
      end
    end
  end

endmodule

// File: tb/tb_pc_target_table.sv
// Bench for pc_target_table: directed vector table, random traffic against a reference model, clr/reset/out-of-range sequences.
module tb_pc_target_table;

  localparam int D  = 12;
  localparam int N  = 8;
  localparam int N6 = 6;

`ifdef PC_TGT_FWD_EN
  localparam bit FWD = 1'b1;
  localparam logic [11:0] SAME_CYCLE_EXP = 12'h0AA;
`else
  localparam bit FWD = 1'b0;
  localparam logic [11:0] SAME_CYCLE_EXP = 12'h008;
`endif

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         clr;
  logic         lookup_req, wr_en, wr_rel;
  logic [2:0]   lut_idx, wr_idx;
  logic [D-1:0] pc_in, wr_data;
  logic         ready, tgt_valid;
  logic [D-1:0] target;

  logic         clr6;
  logic         lookup_req6, wr_en6, wr_rel6;
  logic [2:0]   lut_idx6, wr_idx6;
  logic [D-1:0] pc_in6, wr_data6;
  logic         ready6, tgt_valid6;
  logic [D-1:0] target6;

  int total = 0;
  int bad   = 0;

  int model_val [N];
  bit model_rel [N];
  int model_target;

  typedef struct {
    logic        we;
    logic [2:0]  widx;
    logic [11:0] wdata;
    logic        wrel;
    logic        lk;
    logic [2:0]  lidx;
    logic [11:0] pc;
    logic        exp_valid;
    logic [11:0] exp_target;
  } vec_t;

  vec_t vecs [13];

  always #5 Clk = ~Clk;

  pc_target_table #(.D(D), .N(N)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .clr(clr), .lookup_req(lookup_req), .lut_idx(lut_idx),
    .pc_in(pc_in), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_rel(wr_rel),
    .ready(ready), .tgt_valid(tgt_valid), .target(target)
  );

  pc_target_table #(.D(D), .N(N6)) dut6 (
    .Clk(Clk), .Reset_n(Reset_n), .clr(clr6), .lookup_req(lookup_req6), .lut_idx(lut_idx6),
    .pc_in(pc_in6), .wr_en(wr_en6), .wr_idx(wr_idx6), .wr_data(wr_data6), .wr_rel(wr_rel6),
    .ready(ready6), .tgt_valid(tgt_valid6), .target(target6)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [2:0] widx, input logic [11:0] wdata,
                               input logic wrel, input logic lk, input logic [2:0] lidx,
                               input logic [11:0] pc);
    wr_en      = we;
    wr_idx     = widx;
    wr_data    = wdata;
    wr_rel     = wrel;
    lookup_req = lk;
    lut_idx    = lidx;
    pc_in      = pc;
  endtask

  task automatic idle6();
    lookup_req6 = 1'b0; wr_en6 = 1'b0; wr_rel6 = 1'b0;
    lut_idx6 = '0; wr_idx6 = '0; pc_in6 = '0; wr_data6 = '0;
  endtask

  task automatic stepClock();
    @(posedge Clk);
    #1;
  endtask

  // Signed offset arithmetic straight from the resolution rule, wrapped mod 2^12
  function automatic int resolve_ref(bit rel, int val, int pc);
    int sval;
    if (!rel) return val;
    sval = (val >= 2048) ? val - 4096 : val;
    return ((pc + sval) % 4096 + 4096) % 4096;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      model_val[i] = 0;
      model_rel[i] = 1'b0;
    end
  endtask

  // Counts edges after reset/clr release; ready must rise on exactly the N-th
  task automatic checkInitWindow(input string tag, input bit poke);
    for (int k = 1; k <= N; k++) begin
      if (poke) applyStimulus(1'b1, 3'd6, 12'h777, 1'b0, 1'b1, 3'(k - 1), 12'h100);
      stepClock();
      checkOutput({tag, "_ready"}, 32'(ready), 32'(k == N));
      checkOutput({tag, "_valid"}, 32'(tgt_valid), 32'd0);
      if (!poke) checkOutput({tag, "_ready6"}, 32'(ready6), 32'(k >= N6));
    end
    applyStimulus(1'b0, 3'd0, 12'h0, 1'b0, 1'b0, 3'd0, 12'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd5, 12'h123, 1'b1, 12'h000};
    vecs[1]  = '{1'b1, 3'd2, 12'd22,  1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'h000};
    vecs[2]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd2, 12'h100, 1'b1, 12'h016};
    vecs[3]  = '{1'b1, 3'd3, 12'hFE2, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 12'h016};
    vecs[4]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd3, 12'd100, 1'b1, 12'd70};
    vecs[5]  = '{1'b1, 3'd4, 12'hFFB, 1'b1, 1'b0, 3'd0, 12'h000, 1'b0, 12'd70};
    vecs[6]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd4, 12'd4,   1'b1, 12'hFFF};
    vecs[7]  = '{1'b1, 3'd1, 12'h008, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'hFFF};
    vecs[8]  = '{1'b1, 3'd1, 12'h0AA, 1'b0, 1'b1, 3'd1, 12'h000, 1'b1, SAME_CYCLE_EXP};
    vecs[9]  = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd1, 12'h000, 1'b1, 12'h0AA};
    vecs[10] = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd2, 12'h000, 1'b1, 12'h016};
    vecs[11] = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b1, 3'd3, 12'h010, 1'b1, 12'hFF2};
    vecs[12] = '{1'b0, 3'd0, 12'h000, 1'b0, 1'b0, 3'd0, 12'h000, 1'b0, 12'hFF2};

    Reset_n = 1'b0;
    clr = 1'b0;
    clr6 = 1'b0;
    applyStimulus(1'b0, 3'd0, 12'h0, 1'b0, 1'b0, 3'd0, 12'h0);
    idle6();
    clearModel();
    model_target = 0;
    #1;
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_valid", 32'(tgt_valid), 32'd0);
    checkOutput("rst_target", 32'(target), 32'd0);

    stepClock();
    stepClock();
    Reset_n = 1'b1;
    checkOutput("init0_ready", 32'(ready), 32'd0);
    checkInitWindow("init", 1'b0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].we, vecs[i].widx, vecs[i].wdata, vecs[i].wrel,
                    vecs[i].lk, vecs[i].lidx, vecs[i].pc);
      stepClock();
      checkOutput($sformatf("vec%0d_valid", i), 32'(tgt_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_target", i), 32'(target), 32'(vecs[i].exp_target));
      if (vecs[i].we) begin
        model_val[vecs[i].widx] = int'(vecs[i].wdata);
        model_rel[vecs[i].widx] = vecs[i].wrel;
      end
      if (vecs[i].exp_valid) model_target = int'(vecs[i].exp_target);
    end

    for (int i = 0; i < 300; i++) begin
      logic        we, wrel, lk;
      logic [2:0]  widx, lidx;
      logic [11:0] wdata, pc;
      int          exp_valid;
      we    = 1'($urandom_range(0, 1));
      wrel  = 1'($urandom_range(0, 1));
      lk    = ($urandom_range(0, 3) != 0);
      widx  = 3'($urandom_range(0, N - 1));
      lidx  = ($urandom_range(0, 3) == 0) ? widx : 3'($urandom_range(0, N - 1));
      wdata = 12'($urandom);
      pc    = 12'($urandom);
      exp_valid = 0;
      if (lk) begin
        exp_valid = 1;
        if (FWD && we && widx == lidx)
          model_target = resolve_ref(wrel, int'(wdata), int'(pc));
        else
          model_target = resolve_ref(model_rel[lidx], model_val[lidx], int'(pc));
      end
      if (we) begin
        model_val[widx] = int'(wdata);
        model_rel[widx] = wrel;
      end
      applyStimulus(we, widx, wdata, wrel, lk, lidx, pc);
      stepClock();
      checkOutput($sformatf("rnd%0d_valid", i), 32'(tgt_valid), 32'(exp_valid));
      checkOutput($sformatf("rnd%0d_target", i), 32'(target), 32'(model_target));
    end

    // Make sure several entries are non-zero so the clear is observable
    applyStimulus(1'b1, 3'd2, 12'h016, 1'b0, 1'b0, 3'd0, 12'h0);
    stepClock();
    applyStimulus(1'b1, 3'd3, 12'hFE2, 1'b1, 1'b0, 3'd0, 12'h0);
    stepClock();
    applyStimulus(1'b1, 3'd5, 12'h123, 1'b0, 1'b1, 3'd2, 12'h0);
    stepClock();
    checkOutput("preclr_target", 32'(target), 32'h016);
    model_target = 32'h016;

    clr = 1'b1;
    applyStimulus(1'b1, 3'd5, 12'h333, 1'b0, 1'b1, 3'd5, 12'h0);
    stepClock();
    clr = 1'b0;
    checkOutput("clr_ready", 32'(ready), 32'd0);
    checkOutput("clr_valid", 32'(tgt_valid), 32'd0);
    checkOutput("clr_target_hold", 32'(target), 32'(model_target));
    checkInitWindow("clrinit", 1'b1);
    checkOutput("clrinit_target_hold", 32'(target), 32'(model_target));
    clearModel();

    for (int i = 0; i < 8; i++) begin
      logic [11:0] pc;
      pc = 12'($urandom);
      applyStimulus(1'b0, 3'd0, 12'h0, 1'b0, 1'b1, 3'(i), pc);
      stepClock();
      checkOutput($sformatf("postclr%0d_valid", i), 32'(tgt_valid), 32'd1);
      checkOutput($sformatf("postclr%0d_target", i), 32'(target), 32'd0);
    end

    applyStimulus(1'b1, 3'd1, 12'h0AA, 1'b0, 1'b0, 3'd0, 12'h0);
    stepClock();
    applyStimulus(1'b0, 3'd0, 12'h0, 1'b0, 1'b1, 3'd1, 12'h0);
    stepClock();
    checkOutput("prerst_valid", 32'(tgt_valid), 32'd1);
    checkOutput("prerst_target", 32'(target), 32'h0AA);
    applyStimulus(1'b0, 3'd0, 12'h0, 1'b0, 1'b0, 3'd0, 12'h0);
    #1;
    Reset_n = 1'b0;
    #1;
    checkOutput("asyncrst_valid", 32'(tgt_valid), 32'd0);
    checkOutput("asyncrst_target", 32'(target), 32'd0);
    checkOutput("asyncrst_ready", 32'(ready), 32'd0);
    stepClock();
    Reset_n = 1'b1;
    checkInitWindow("reinit", 1'b0);
    clearModel();

    wr_en6 = 1'b1; wr_idx6 = 3'd7; wr_data6 = 12'h5A5; wr_rel6 = 1'b0;
    lookup_req6 = 1'b1; lut_idx6 = 3'd7; pc_in6 = 12'h200;
    stepClock();
    checkOutput("n6_oor_valid", 32'(tgt_valid6), 32'd1);
    checkOutput("n6_oor_target", 32'(target6), 32'd0);
    wr_idx6 = 3'd5; wr_data6 = 12'h0C3; lut_idx6 = 3'd0; pc_in6 = 12'h100;
    stepClock();
    checkOutput("n6_idx0_target", 32'(target6), 32'd0);
    wr_idx6 = 3'd6; wr_data6 = 12'h111; lut_idx6 = 3'd5; pc_in6 = 12'h000;
    stepClock();
    checkOutput("n6_idx5_target", 32'(target6), 32'h0C3);
    wr_idx6 = 3'd0; wr_data6 = 12'hFFF; wr_rel6 = 1'b1; lut_idx6 = 3'd7; pc_in6 = 12'h200;
    stepClock();
    checkOutput("n6_oor7_target", 32'(target6), 32'd0);
    wr_en6 = 1'b0; lut_idx6 = 3'd6;
    stepClock();
    checkOutput("n6_oor6_target", 32'(target6), 32'd0);
    lut_idx6 = 3'd0; pc_in6 = 12'h000;
    stepClock();
    checkOutput("n6_rel_target", 32'(target6), 32'hFFF);
    checkOutput("n6_rel_valid", 32'(tgt_valid6), 32'd1);
    idle6();
    stepClock();
    checkOutput("n6_idle_valid", 32'(tgt_valid6), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
